pack_recv: RTL and testbench

Receive-side counterpart of the packet-to-byte sender. Accepts the byte stream from the serial front end, hunts for the `FF FF FF 7F` sync sequence, and reassembles 16-byte frames into 8 × 16-bit words. Holds up to four complete frames and presents them to the downstream packet consumer through a packet/word strobe interface. This interface matches the one the sender's upstream side already consumes.

---
 rtl/pack_pkg.sv | 26 ++
 rtl/pack_slot_ram.sv | 46 ++++
 rtl/pack_recv.sv | 194 +++++++++++++++++++
 tb/tb_pack_recv.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pack_pkg
// Brief    : Shared constants and types for the packet sender/receiver pair.
//            Sync marker, frame geometry and the receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pack_pkg;

  // Four-byte marker that precedes frames on the line (FF FF FF 7F)
  localparam logic [31:0] SYNC_WORD   = 32'hFFFF_FF7F;
  localparam int          FRAME_BYTES = 16;
  localparam int          FRAME_WORDS = 8;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } rxState_t;

  // True when the newest four bytes (oldest in the top byte) form the marker
  function automatic logic isSync(input logic [31:0] window);
    return window == SYNC_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pack_slot_ram.sv
`default_nettype none
// ============================================================================
// Module   : pack_slot_ram
// Brief    : NSLOT x 8 x 16-bit simple dual-port frame store. One write port
//            with byte-lane enables, one read port with a registered output.
// Revision : 1.0 - initial release
// ============================================================================
module pack_slot_ram
  import pack_pkg::*;
#(
  parameter int NSLOT  = 4,
  parameter int ADDR_W = $clog2(NSLOT * FRAME_WORDS)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [1:0]        wrBe,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [15:0]       wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [15:0]       rdData
);

  localparam int c_depth = NSLOT * FRAME_WORDS;

  // One byte-wide bank per lane so a single received byte updates half a word
  for (genvar lane = 0; lane < 2; lane++) begin : g_lane
    logic [7:0] r_mem [c_depth];
    logic [7:0] r_rd;

    // Lane write
    always_ff @(posedge clk) begin
      if (wrEn && wrBe[lane]) begin
        r_mem[wrAddr] <= wrData[8*lane +: 8];
      end
    end

    // Registered lane read
    always_ff @(posedge clk) begin
      r_rd <= r_mem[rdAddr];
    end

    assign rdData[8*lane +: 8] = r_rd;
  end

endmodule
`default_nettype wire

// File: rtl/pack_recv.sv
`default_nettype none
// ============================================================================
// Module   : pack_recv
// Brief    : Byte-stream receiver. Hunts for the FF FF FF 7F marker, rebuilds
//            16-byte frames into 8 x 16-bit words, buffers up to NSLOT frames
//            and serves them through a packet/word strobe interface.
// Revision : 1.0 - initial release
// ============================================================================
module pack_recv
  import pack_pkg::*;
#(
  parameter int NSLOT   = 4,
  parameter int STRETCH = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ByteValid,
  input  logic [7:0]  ByteIn,
  input  logic        ByteErr,
  output logic        SyncOk,
  output logic        PacketAvail,
  input  logic        PacketNext,
  input  logic        PacketNextWd,
  output logic [15:0] PacketOut,
  output logic        PacketOverf
);

  localparam int c_ptrW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int c_cntW = c_ptrW + 1;
  localparam int c_biW  = $clog2(FRAME_BYTES);
  localparam int c_wdW  = $clog2(FRAME_WORDS);
  localparam int c_wpW  = c_wdW + 1;
  localparam int c_strW = $clog2(STRETCH + 1);
  localparam int c_adrW = c_ptrW + c_wdW;

  localparam logic [c_cntW-1:0] c_slots    = c_cntW'(NSLOT);
  localparam logic [c_biW-1:0]  c_lastByte = c_biW'(FRAME_BYTES - 1);
  localparam logic [c_biW-1:0]  c_syncByte = c_biW'(3);
  // Word pointer: all-ones means "before word 0" so one increment lands on 0
  localparam logic [c_wpW-1:0]  c_wpBefore = '1;
  localparam logic [c_wpW-1:0]  c_wpEnd    = c_wpW'(FRAME_WORDS);

  // Receive side
  rxState_t          r_state;
  logic [c_biW-1:0]  r_bi;
  logic [31:0]       r_shift;
  logic              r_lost;

  // Buffer / consumer side
  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_ptrW-1:0] r_rdPtr;
  logic [c_ptrW-1:0] r_openSlot;
  logic [c_cntW-1:0] r_complete;
  logic              r_open;
  logic [c_wpW-1:0]  r_wp;
  logic              r_wordValid;
  logic [c_strW-1:0] r_stretch;

  logic [31:0]       w_window;
  logic              w_byteAcc;
  logic              w_syncHit;
  logic [c_cntW-1:0] w_used;
  logic              w_noFree;
  logic              w_ramWe;
  logic              w_lastByte;
  logic              w_commit;
  logic              w_drop;
  logic              w_take;
  logic              w_openNext;
  logic [c_ptrW-1:0] w_openSlotNext;
  logic [c_wpW-1:0]  w_wpNext;
  logic [15:0]       w_ramRd;

  assign w_byteAcc  = ByteValid && !ByteErr;
  assign w_window   = {r_shift[23:0], ByteIn};
  assign w_syncHit  = isSync(w_window);
  assign w_used     = r_complete + c_cntW'(r_open);
  assign w_noFree   = (w_used == c_slots);
  // With no free slot the write pointer aliases a live slot, so writes are
  // suppressed and the frame is remembered as lost instead.
  assign w_ramWe    = w_byteAcc && (r_state == FRAME) && !w_noFree;
  assign w_lastByte = w_byteAcc && (r_state == FRAME) && (r_bi == c_lastByte);
  assign w_commit   = w_lastByte && !w_noFree && !r_lost;
  assign w_drop     = w_lastByte && !w_commit;
  assign w_take     = PacketNext && (r_complete != '0);

  // Next consumer view: PacketNext opens/frees, otherwise PacketNextWd steps
  always_comb begin
    w_openNext     = r_open;
    w_openSlotNext = r_openSlot;
    w_wpNext       = r_wp;
    if (PacketNext) begin
      w_openNext = w_take;
      if (w_take) begin
        w_openSlotNext = r_rdPtr;
        w_wpNext       = c_wpBefore;
      end
    end else if (PacketNextWd && (r_wp != c_wpEnd)) begin
      w_wpNext = r_wp + c_wpW'(1);
    end
  end

  // Sync hunt and byte-index tracking; an error always forces a fresh hunt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= HUNT;
      r_bi    <= '0;
      r_shift <= '0;
      r_lost  <= 1'b0;
    end else if (ByteErr) begin
      r_state <= HUNT;
      r_bi    <= '0;
      r_shift <= '0;
      r_lost  <= 1'b0;
    end else if (ByteValid) begin
      r_shift <= w_window;
      case (r_state)
        HUNT: begin
          if (w_syncHit) begin
            r_state <= FRAME;
            r_bi    <= '0;
            r_lost  <= 1'b0;
          end
        end
        FRAME: begin
          if (((r_bi == c_syncByte) && w_syncHit) || (r_bi == c_lastByte)) begin
            r_bi   <= '0;
            r_lost <= 1'b0;
          end else begin
            r_bi   <= r_bi + c_biW'(1);
            r_lost <= r_lost | w_noFree;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  // Slot bookkeeping and the open frame's word pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_openSlot  <= '0;
      r_complete  <= '0;
      r_open      <= 1'b0;
      r_wp        <= '0;
      r_wordValid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wrPtr <= r_wrPtr + c_ptrW'(1);
      end
      if (w_take) begin
        r_rdPtr <= r_rdPtr + c_ptrW'(1);
      end
      r_complete  <= r_complete + c_cntW'(w_commit) - c_cntW'(w_take);
      r_open      <= w_openNext;
      r_openSlot  <= w_openSlotNext;
      r_wp        <= w_wpNext;
      r_wordValid <= w_openNext && (w_wpNext < c_wpEnd);
    end
  end

  // Overflow indicator: reload on a dropped frame, then count down to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stretch <= '0;
    end else if (w_drop) begin
      r_stretch <= c_strW'(STRETCH);
    end else if (r_stretch != '0) begin
      r_stretch <= r_stretch - c_strW'(1);
    end
  end

  pack_slot_ram #(
    .NSLOT  (NSLOT),
    .ADDR_W (c_adrW)
  ) u_ram (
    .clk    (clk),
    .wrEn   (w_ramWe),
    .wrBe   (r_bi[0] ? 2'b10 : 2'b01),
    .wrAddr ({r_wrPtr, r_bi[c_biW-1:1]}),
    .wrData ({ByteIn, ByteIn}),
    .rdAddr ({w_openSlotNext, w_wpNext[c_wdW-1:0]}),
    .rdData (w_ramRd)
  );

  assign SyncOk      = (r_state == FRAME);
  assign PacketAvail = (r_complete != '0);
  assign PacketOverf = (r_stretch != '0);
  assign PacketOut   = r_wordValid ? w_ramRd : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_pack_recv.sv
`default_nettype none
// ============================================================================
// Module   : tb_pack_recv
// Brief    : Self-checking bench for pack_recv with a byte-stream reference
//            model (sync hunt, frame queue, consumer view, overflow stretch).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pack_recv;
  import pack_pkg::*;

  localparam int NSLOT   = 4;
  localparam int STRETCH = 2047;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteErr = 1'b0;
  logic        PacketNext = 1'b0;
  logic        PacketNextWd = 1'b0;
  logic        SyncOk;
  logic        PacketAvail;
  logic [15:0] PacketOut;
  logic        PacketOverf;

  always #5 clk = ~clk;

  pack_recv #(.NSLOT(NSLOT), .STRETCH(STRETCH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ByteValid    (ByteValid),
    .ByteIn       (ByteIn),
    .ByteErr      (ByteErr),
    .SyncOk       (SyncOk),
    .PacketAvail  (PacketAvail),
    .PacketNext   (PacketNext),
    .PacketNextWd (PacketNextWd),
    .PacketOut    (PacketOut),
    .PacketOverf  (PacketOverf)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frames as 128-bit vectors, byte i at bits [8i +: 8]
  logic [127:0] mFrames[$];
  logic [127:0] mOpenFrame;
  logic [127:0] mCur;
  logic [31:0]  mHist;
  bit           mOpen;
  bit           mSynced;
  int           mWp;
  int           mCurN;
  int           mStretch;

  task automatic modelReset();
    mFrames.delete();
    mOpenFrame = '0;
    mCur       = '0;
    mHist      = '0;
    mOpen      = 1'b0;
    mSynced    = 1'b0;
    mWp        = 0;
    mCurN      = 0;
    mStretch   = 0;
  endtask

  function automatic logic [15:0] modelOut();
    if (mOpen && mWp >= 0 && mWp < FRAME_WORDS) return mOpenFrame[16*mWp +: 16];
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, model update and output comparison
  task automatic tick(input logic bv, input logic [7:0] b, input logic be,
                      input logic pn, input logic pw);
    int usedPre;
    bit availPre;
    bit drop;
    ByteValid = bv; ByteIn = b; ByteErr = be; PacketNext = pn; PacketNextWd = pw;
    @(posedge clk);
    usedPre  = mFrames.size() + (mOpen ? 1 : 0);
    availPre = (mFrames.size() != 0);
    drop     = 1'b0;
    if (pn) begin
      if (availPre) begin
        mOpenFrame = mFrames.pop_front();
        mOpen = 1'b1;
        mWp   = -1;
      end else begin
        mOpen = 1'b0;
      end
    end else if (pw && mWp < FRAME_WORDS) begin
      mWp++;
    end
    if (be) begin
      mSynced = 1'b0; mHist = '0; mCurN = 0;
    end else if (bv) begin
      mHist = {mHist[23:0], b};
      if (!mSynced) begin
        if (mHist == SYNC_WORD) begin
          mSynced = 1'b1; mCurN = 0;
        end
      end else begin
        mCur[8*mCurN +: 8] = b;
        mCurN++;
        if (mCurN == 4 && mHist == SYNC_WORD) begin
          mCurN = 0;
        end else if (mCurN == FRAME_BYTES) begin
          mCurN = 0;
          if (usedPre < NSLOT) mFrames.push_back(mCur);
          else drop = 1'b1;
        end
      end
    end
    if (drop) mStretch = STRETCH;
    else if (mStretch > 0) mStretch--;
    #1;
    ByteValid = 1'b0; ByteErr = 1'b0; PacketNext = 1'b0; PacketNextWd = 1'b0;
    check("SyncOk", 16'(SyncOk), 16'(mSynced));
    check("PacketAvail", 16'(PacketAvail), 16'(mFrames.size() != 0));
    check("PacketOut", PacketOut, modelOut());
    check("PacketOverf", 16'(PacketOverf), 16'(mStretch != 0));
  endtask

  task automatic sendByte(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendSync();
    sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h7F);
  endtask

  task automatic sendRandFrame();
    sendSync();
    for (int i = 0; i < FRAME_BYTES; i++) sendByte(8'($urandom));
  endtask

  // Byte with random idle gaps and random consumer strobes around it
  task automatic sendByteBusy(input logic [7:0] b);
    int gaps;
    gaps = $urandom_range(2);
    for (int g = 0; g < gaps; g++)
      tick(1'b0, 8'h00, 1'b0, $urandom_range(7) == 0, $urandom_range(1) == 0);
    tick(1'b1, b, 1'b0, $urandom_range(7) == 0, $urandom_range(1) == 0);
  endtask

  task automatic readFrame();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int w = 0; w < FRAME_WORDS + 1; w++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    while (mFrames.size() != 0) tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    modelReset();
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_SyncOk", 16'(SyncOk), 16'd0);
    check("rst_PacketAvail", 16'(PacketAvail), 16'd0);
    check("rst_PacketOut", PacketOut, 16'h0000);
    check("rst_PacketOverf", 16'(PacketOverf), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic alignment: 00 FF FF FF 7F then 00..0F
    sendByte(8'h00);
    sendSync();
    check("basic_sync", 16'(SyncOk), 16'd1);
    for (int i = 0; i < 16; i++) sendByte(8'(i));
    check("basic_avail", 16'(PacketAvail), 16'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int w = 0; w < FRAME_WORDS; w++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("basic_word", PacketOut, {8'(2*w + 1), 8'(2*w)});
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("basic_ninth", PacketOut, 16'h0000);

    // Boundary sync discard: frame, FF FF FF 7F, then 10..1F
    for (int i = 0; i < 16; i++) sendByte(8'(8'h40 + i));
    sendSync();
    for (int i = 0; i < 16; i++) sendByte(8'(8'h10 + i));
    readFrame();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("bsync_avail_after_two", 16'(PacketAvail), 16'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("bsync_w0", PacketOut, 16'h1110);
    for (int w = 1; w < FRAME_WORDS; w++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Near-sync pattern is frame data
    sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h00);
    for (int i = 4; i < 16; i++) sendByte(8'(i));
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("near_w0", PacketOut, 16'hFFFF);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("near_w1", PacketOut, 16'h00FF);
    for (int w = 2; w < FRAME_WORDS + 1; w++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random frames with a concurrently active consumer (buffer never full)
    for (int f = 0; f < 6; f++) begin
      while (mFrames.size() + (mOpen ? 1 : 0) >= NSLOT) tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      sendByteBusy(8'hFF); sendByteBusy(8'hFF); sendByteBusy(8'hFF); sendByteBusy(8'h7F);
      for (int i = 0; i < FRAME_BYTES; i++) sendByteBusy(8'($urandom));
    end
    drain();

    // Overflow: five frames, no reads
    for (int f = 0; f < 4; f++) sendRandFrame();
    check("ovf_avail4", 16'(PacketAvail), 16'd1);
    check("ovf_none_yet", 16'(PacketOverf), 16'd0);
    sendRandFrame();
    n = 0;
    while (PacketOverf && n < 3000) begin
      n++;
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    check("ovf_stretch_len", 16'(n), 16'd2047);
    for (int f = 0; f < 4; f++) readFrame();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_drained", 16'(PacketAvail), 16'd0);

    // Error mid-frame, with a simultaneous ByteValid
    sendSync();
    for (int i = 0; i < 8; i++) sendByte(8'($urandom));
    tick(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    check("err_syncok", 16'(SyncOk), 16'd0);
    for (int i = 0; i < 16; i++) sendByte(8'(8'h20 + i));
    check("err_no_avail", 16'(PacketAvail), 16'd0);
    sendRandFrame();
    check("err_resync_avail", 16'(PacketAvail), 16'd1);
    readFrame();
    drain();

    // Reset mid-frame: one frame open, two buffered, one partial
    for (int f = 0; f < 3; f++) sendRandFrame();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sendSync();
    for (int i = 0; i < 5; i++) sendByte(8'($urandom));
    #2;
    rst = 1'b0;
    #1;
    check("amid_SyncOk", 16'(SyncOk), 16'd0);
    check("amid_PacketAvail", 16'(PacketAvail), 16'd0);
    check("amid_PacketOut", PacketOut, 16'h0000);
    check("amid_PacketOverf", 16'(PacketOverf), 16'd0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) sendByte(8'(8'h30 + i));
    check("post_rst_no_avail", 16'(PacketAvail), 16'd0);
    check("post_rst_no_sync", 16'(SyncOk), 16'd0);
    sendRandFrame();
    check("post_rst_avail", 16'(PacketAvail), 16'd1);
    readFrame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
